// File: rtl/adder_pkg.sv
// adder_pkg: shared state encoding and sizing helpers for the serial adder.
package adder_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
   localparam int MAX_WIDTH = 32;
   function automatic int cnt_w(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction
endpackage

// File: rtl/full_adder.sv
// full_adder: single-bit full adder shared as the serial datapath.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder, LSB first through one full_adder,
// returning sum, carry-out and signed overflow with a one-cycle done pulse.
module serial_adder_ctrl
   import adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);
   localparam int CW = cnt_w(WIDTH);
   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
   logic             c_q, c_d, cout_q, cout_d, ovf_q, ovf_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             fa_s, fa_c, accept, last;
   logic [WIDTH-1:0] res_nx;
   full_adder u_fa (.a(a_q[0]), .b(b_q[0]), .cin(c_q), .sum(fa_s), .cout(fa_c));
   assign accept = start && (state_q != RUN);
   assign last   = (state_q == RUN) && (cnt_q == CW'(WIDTH - 1));
   // new sum bit enters at the MSB so the LSB-first stream lands in place
   assign res_nx = WIDTH'({fa_s, res_q} >> 1);
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      c_d     = c_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      if (accept) begin
         state_d = RUN;
         a_d     = a;
         b_d     = b;
         c_d     = cin;
         cnt_d   = '0;
      end else if (state_q == RUN) begin
         a_d   = a_q >> 1;
         b_d   = b_q >> 1;
         res_d = res_nx;
         c_d   = fa_c;
         cnt_d = cnt_q + CW'(1);
         if (last) begin
            state_d = DONE;
            sum_d   = res_nx;
            cout_d  = fa_c;
            ovf_d   = c_q ^ fa_c;
         end
      end else begin
         state_d = IDLE;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         c_q     <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end
   assign busy     = (state_q == RUN);
   assign done     = (state_q == DONE);
   assign sum      = sum_q;
   assign cout     = cout_q;
   assign overflow = ovf_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: WIDTH 8/4/1 instances checked against an arithmetic reference.
module tb_serial_adder_ctrl;
   logic       clk = 1'b0, rst = 1'b1;
   logic       st8 = 1'b0, st4 = 1'b0, st1 = 1'b0, cin = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic [3:0] a4 = '0, b4 = '0;
   logic       a1 = 1'b0, b1 = 1'b0;
   logic       busy8, done8, cout8, ovf8, busy4, done4, cout4, ovf4, busy1, done1, cout1, ovf1;
   logic [7:0] sum8;
   logic [3:0] sum4;
   logic       sum1;
   int         cur_w = 8, n_cmp = 0, n_bad = 0;
   logic       busy_w, done_w, cout_w, ovf_w;
   logic [7:0] sum_w;

   always #5 clk = ~clk;

   serial_adder_ctrl #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .start(st8), .a(a8), .b(b8), .cin(cin),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8));
   serial_adder_ctrl #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .start(st4), .a(a4), .b(b4), .cin(cin),
      .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .overflow(ovf4));
   serial_adder_ctrl #(.WIDTH(1)) u1 (.clk(clk), .rst(rst), .start(st1), .a(a1), .b(b1), .cin(cin),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ovf1));

   always_comb begin
      busy_w = busy8; done_w = done8; sum_w = sum8; cout_w = cout8; ovf_w = ovf8;
      if (cur_w == 4) begin
         busy_w = busy4; done_w = done4; sum_w = {4'h0, sum4}; cout_w = cout4; ovf_w = ovf4;
      end else if (cur_w == 1) begin
         busy_w = busy1; done_w = done1; sum_w = {7'h0, sum1}; cout_w = cout1; ovf_w = ovf1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (w=%0d t=%0t)", tag, got, exp, cur_w, $time);
      end
   endtask

   // reference: plain integer addition, overflow from operand/result sign bits
   task automatic ref_add(input int w, input logic [7:0] a, b, input logic c,
                          output logic [7:0] s, output logic co, output logic ov);
      int unsigned m, full;
      logic sa, sb, ss;
      m    = (32'd1 << w) - 1;
      full = (a & m) + (b & m) + c;
      s    = 8'(full & m);
      co   = full[w];
      sa   = a[w-1]; sb = b[w-1]; ss = s[w-1];
      ov   = (sa == sb) && (ss != sa);
   endtask

   task automatic drive(input int w, input logic [7:0] a, b, input logic c, input logic s);
      cur_w = w;
      a8 = a; b8 = b; a4 = a[3:0]; b4 = b[3:0]; a1 = a[0]; b1 = b[0]; cin = c;
      st8 = s && (w == 8); st4 = s && (w == 4); st1 = s && (w == 1);
   endtask

   task automatic run(input int w, input logic [7:0] a, b, input logic c);
      logic [7:0] es;
      logic eco, eov;
      int n;
      ref_add(w, a, b, c, es, eco, eov);
      @(negedge clk) drive(w, a, b, c, 1'b1);
      @(negedge clk) drive(w, a, b, c, 1'b0);
      n = 0;
      while (busy_w && n < 40) begin
         n++;
         @(negedge clk);
      end
      check("busy_cycles", n, w);
      check("done", done_w, 1);
      check("sum", sum_w, es);
      check("cout", cout_w, eco);
      check("ovf", ovf_w, eov);
      @(negedge clk);
      check("done_pulse", done_w, 0);
      check("sum_hold", sum_w, es);
   endtask

   initial begin
      logic [7:0] ra, rb;
      int n;
      bit saw_done;
      #12;
      check("rst_busy", busy8, 0);
      check("rst_done", done8, 0);
      check("rst_sum", sum8, 0);
      check("rst_cout", cout8, 0);
      check("rst_ovf", ovf8, 0);
      @(negedge clk) rst = 1'b0;
      run(8, 8'h5A, 8'hA5, 1'b0);
      check("basic_const", sum8, 8'hFF);
      run(8, 8'hFF, 8'h01, 1'b0);
      check("wrap_cout", cout8, 1);
      run(8, 8'h7F, 8'h00, 1'b1);
      check("ovf_const", {ovf8, sum8}, 9'h180);
      // start while busy is ignored; start held into DONE is accepted back-to-back
      @(negedge clk) drive(8, 8'h10, 8'h20, 1'b0, 1'b1);
      @(negedge clk) drive(8, 8'h10, 8'h20, 1'b0, 1'b0);
      for (int c = 1; c <= 8; c++) begin
         if (c == 3) drive(8, 8'hFF, 8'hFF, 1'b0, 1'b1);
         if (c == 4) drive(8, 8'hFF, 8'hFF, 1'b0, 1'b0);
         if (c == 5) drive(8, 8'h01, 8'h01, 1'b1, 1'b1);
         check("b2b_busy", busy8, 1);
         @(negedge clk);
      end
      check("b2b_done1", done8, 1);
      check("b2b_sum1", sum8, 8'h30);
      check("b2b_cout1", cout8, 0);
      @(negedge clk) drive(8, 8'h01, 8'h01, 1'b1, 1'b0);
      check("b2b_busy2", busy8, 1);
      repeat (4) @(negedge clk);
      check("b2b_sum_stable", sum8, 8'h30);
      repeat (4) @(negedge clk);
      check("b2b_done2", done8, 1);
      check("b2b_sum2", sum8, 8'h03);
      // reset in the middle of a run
      @(negedge clk) drive(8, 8'h33, 8'h44, 1'b0, 1'b1);
      @(negedge clk) drive(8, 8'h33, 8'h44, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst_busy", busy8, 0);
      check("mid_rst_sum", sum8, 0);
      check("mid_rst_cout", cout8, 0);
      check("mid_rst_ovf", ovf8, 0);
      @(negedge clk) rst = 1'b0;
      saw_done = 1'b0;
      n = 0;
      repeat (12) begin
         @(negedge clk);
         saw_done |= done8;
         n += int'(busy8);
      end
      check("mid_rst_no_done", saw_done, 0);
      check("mid_rst_no_busy", n, 0);
      run(8, 8'h33, 8'h44, 1'b0);
      for (int i = 0; i < 40; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         run(8, ra, rb, 1'($urandom));
      end
      for (int i = 0; i < 512; i++) run(4, 8'(i & 15), 8'((i >> 4) & 15), 1'(i >> 8));
      for (int i = 0; i < 8; i++) run(1, 8'(i & 1), 8'((i >> 1) & 1), 1'(i >> 2));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
